inst_fetch_ctrl: RTL and testbench

//  Instruction-fetch sequencer for the Lab 5 datapath. Owns the PC, drives the byte address of
//  the combinational instruction memory, registers each fetched word into an instruction register
//  and hands it to decode over a valid/ready handshake. Supports stall, redirect (branch/jump),
//  a programmed end address and a sticky misalignment flag.

---
 rtl/inst_fetch_ctrl.sv | 125 ++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, registers fetched words into ir and hands them to decode
// over valid/ready. Optional fetch counter is enabled by defining FETCH_CNT_EN.
module inst_fetch_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
  parameter logic [ADDR_W-1:0] LAST_PC  = 8'h44
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              misalign_err,
  output logic              busy,
  output logic              done,
  output logic [15:0]       fetch_count
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HALT} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [DATA_W-1:0] ir_reg, ir_next;
  logic [ADDR_W-1:0] ir_pc_reg, ir_pc_next;
  logic              valid_reg, valid_next;
  logic              misalign_reg, misalign_next;

  logic advance;
  logic redirect_take;
  logic start_take;

  assign start_take    = start && (state_reg == IDLE || state_reg == HALT);
  assign redirect_take = redirect_en && (state_reg == FETCH || state_reg == DRAIN);
  assign advance       = (state_reg == FETCH) && (!valid_reg || out_ready) && !redirect_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      pc_reg       <= RESET_PC;
      ir_reg       <= '0;
      ir_pc_reg    <= '0;
      valid_reg    <= 1'b0;
      misalign_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      ir_reg       <= ir_next;
      ir_pc_reg    <= ir_pc_next;
      valid_reg    <= valid_next;
      misalign_reg <= misalign_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    ir_next       = ir_reg;
    ir_pc_next    = ir_pc_reg;
    valid_next    = valid_reg;
    misalign_next = misalign_reg;
    // Redirect wins over fetch/drain; a concurrent handshake still completes, the flush discards ir.
    if (redirect_take) begin
      state_next = FETCH;
      pc_next    = {redirect_pc[ADDR_W-1:2], 2'b00};
      valid_next = 1'b0;
      if (redirect_pc[1:0] != 2'b00) misalign_next = 1'b1;
    end else begin
      case (state_reg)
        IDLE, HALT: begin
          if (start_take) begin
            state_next = FETCH;
            pc_next    = RESET_PC;
            valid_next = 1'b0;
          end
        end
        FETCH: begin
          if (advance) begin
            ir_next    = imem_data;
            ir_pc_next = pc_reg;
            valid_next = 1'b1;
            if (pc_reg == LAST_PC) state_next = DRAIN;
            else pc_next = pc_reg + ADDR_W'(4);
          end
        end
        DRAIN: begin
          if (valid_reg && out_ready) begin
            valid_next = 1'b0;
            state_next = HALT;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

`ifdef FETCH_CNT_EN
  logic [15:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_reg <= 16'h0;
    else if (start_take) count_reg <= 16'h0;
    else if (advance && count_reg != 16'hFFFF) count_reg <= count_reg + 16'h1;
  end

  assign fetch_count = count_reg;
`else
  assign fetch_count = 16'h0;
`endif

  assign imem_addr    = pc_reg;
  assign ir           = ir_reg;
  assign ir_pc        = ir_pc_reg;
  assign out_valid    = valid_reg;
  assign misalign_err = misalign_reg;
  assign busy         = (state_reg == FETCH) || (state_reg == DRAIN);
  assign done         = (state_reg == HALT);

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: directed program scenarios plus randomized traffic against a
// behavioural model of the fetch sequencer, compared every falling edge.
module tb_inst_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ir;
  logic [7:0]  ir_pc;
  logic        redirect_en;
  logic [7:0]  redirect_pc;
  logic        misalign_err;
  logic        busy;
  logic        done;
  logic [15:0] fetch_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:63];
  assign imem_data = mem[imem_addr[7:2]];

  localparam logic [31:0] PROG [0:17] = '{
    32'h00007033, 32'h00100093, 32'h00200113, 32'h00308193, 32'h00408213, 32'h00508293,
    32'h00608313, 32'h00708393, 32'h00208433, 32'h001004b3, 32'h40110533, 32'h003125b3,
    32'h00b57633, 32'h00c566b3, 32'h00d64733, 32'h00e787b3, 32'h00f80833, 32'h4D244893};

  inst_fetch_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .imem_addr(imem_addr), .imem_data(imem_data),
    .out_valid(out_valid), .out_ready(out_ready), .ir(ir), .ir_pc(ir_pc),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc), .misalign_err(misalign_err),
    .busy(busy), .done(done), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode 0=idle, 1=fetching, 2=draining, 3=halted
  int          m_mode;
  logic [7:0]  m_pc;
  logic [31:0] m_ir;
  logic [7:0]  m_irpc;
  logic        m_v;
  logic        m_mis;
  int          m_fetches;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pc = 8'h00; m_ir = 0; m_irpc = 0; m_v = 0; m_mis = 0; m_fetches = 0;
  endtask

  // Apply one clock edge's worth of the fetch rules to the model, using the inputs seen at the edge.
  task automatic model_edge();
    if (m_mode == 0 || m_mode == 3) begin
      if (start) begin
        m_mode = 1; m_pc = 8'h00; m_v = 0; m_fetches = 0;
      end
    end else if (redirect_en) begin
      m_mode = 1;
      m_pc   = redirect_pc & 8'hFC;
      m_v    = 0;
      if (redirect_pc % 4 != 0) m_mis = 1;
    end else if (m_mode == 1) begin
      if (!m_v || out_ready) begin
        m_ir   = mem[m_pc / 4];
        m_irpc = m_pc;
        m_v    = 1;
        if (m_fetches < 65535) m_fetches++;
        if (m_pc == 8'h44) m_mode = 2;
        else m_pc = 8'((int'(m_pc) + 4) % 256);
      end
    end else if (m_v && out_ready) begin
      m_v = 0; m_mode = 3;
    end
  endtask

  function automatic logic [15:0] exp_count();
`ifdef FETCH_CNT_EN
    return 16'(m_fetches);
`else
    return 16'h0;
`endif
  endfunction

  always @(negedge clk) begin
    chk("imem_addr", 32'(imem_addr), 32'(m_pc));
    chk("out_valid", 32'(out_valid), 32'(m_v));
    chk("ir", ir, m_ir);
    chk("ir_pc", 32'(ir_pc), 32'(m_irpc));
    chk("misalign_err", 32'(misalign_err), 32'(m_mis));
    chk("busy", 32'(busy), 32'(m_mode == 1 || m_mode == 2));
    chk("done", 32'(done), 32'(m_mode == 3));
    chk("fetch_count", 32'(fetch_count), 32'(exp_count()));
  end

  task automatic step();
    @(posedge clk);
    if (reset) model_reset();
    else model_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic async_reset();
    reset = 1'b1;
    #1;
    model_reset();
    chk("async_rst_valid", 32'(out_valid), 32'h0);
    chk("async_rst_pc", 32'(imem_addr), 32'h0);
    chk("async_rst_busy", 32'(busy), 32'h0);
    chk("async_rst_mis", 32'(misalign_err), 32'h0);
    #1;
    reset = 1'b0;
  endtask

  task automatic run_to_halt(input string name);
    int n = 0;
    while (!done && n < 60) begin
      step();
      n++;
    end
    chk(name, 32'(done), 32'h1);
  endtask

  initial begin
    logic [7:0] rp;
    model_reset();
    for (int i = 0; i < 64; i++) mem[i] = (i < 18) ? PROG[i] : $urandom;
    reset = 1'b1; start = 0; out_ready = 1; redirect_en = 0; redirect_pc = 0;
    @(negedge clk); #1;
    step(); step();
    chk("reset_valid", 32'(out_valid), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    reset = 1'b0;
    step();

    // Full program run at one instruction per cycle
    start = 1; step(); start = 0;
    chk("s1_busy_after_start", 32'(busy), 32'h1);
    step();
    chk("s1_ir0", ir, 32'h00007033);
    chk("s1_irpc0", 32'(ir_pc), 32'h00);
    step();
    chk("s1_ir1", ir, 32'h00100093);
    step();
    chk("s1_ir2", ir, 32'h00200113);
    chk("s1_irpc2", 32'(ir_pc), 32'h08);
    for (int i = 0; i < 40 && ir_pc != 8'h44; i++) step();
    chk("s1_ir17", ir, 32'h4D244893);
    chk("s1_irpc17", 32'(ir_pc), 32'h44);
    step();
    chk("s1_done", 32'(done), 32'h1);
    chk("s1_busy", 32'(busy), 32'h0);
`ifdef FETCH_CNT_EN
    chk("s1_count", 32'(fetch_count), 32'd18);
`else
    chk("s1_count", 32'(fetch_count), 32'd0);
`endif

    // Stall while ir holds word 2
    start = 1; step(); start = 0;
    step(); step(); step();
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("s2_ir_hold", ir, 32'h00200113);
      chk("s2_irpc_hold", 32'(ir_pc), 32'h08);
      chk("s2_pc_hold", 32'(imem_addr), 32'h0C);
    end
    out_ready = 1; step();
    chk("s2_ir_next", ir, 32'h00308193);

    // Redirect while stalled
    out_ready = 0; step();
    redirect_en = 1; redirect_pc = 8'h20; step();
    chk("s3_flush", 32'(out_valid), 32'h0);
    redirect_en = 0; out_ready = 1; step();
    chk("s3_ir", ir, 32'h00208433);
    chk("s3_irpc", 32'(ir_pc), 32'h20);
    chk("s3_mis", 32'(misalign_err), 32'h0);

    // Misaligned redirect target is truncated and flagged stickily
    redirect_en = 1; redirect_pc = 8'h23; step();
    chk("s4_pc", 32'(imem_addr), 32'h20);
    chk("s4_mis", 32'(misalign_err), 32'h1);
    redirect_en = 0; step(); step();
    chk("s4_mis_sticky", 32'(misalign_err), 32'h1);

    // Asynchronous reset while fetching at 0x14
    redirect_en = 1; redirect_pc = 8'h14; step(); redirect_en = 0;
    chk("s5_pc14", 32'(imem_addr), 32'h14);
    async_reset();
    start = 1; step(); start = 0;
    run_to_halt("s5_halt_timeout");
    start = 1; step(); start = 0;
    chk("s5_count_cleared", 32'(fetch_count), 32'h0);
    step();
    chk("s5_restart_ir", ir, 32'h00007033);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      out_ready   = ($urandom_range(0, 3) != 0);
      start       = ($urandom_range(0, 19) == 0);
      redirect_en = ($urandom_range(0, 24) == 0);
      rp = 8'($urandom);
      if ($urandom_range(0, 3) != 0) rp[1:0] = 2'b00;
      redirect_pc = rp;
      if ($urandom_range(0, 299) == 0) async_reset();
      step();
    end
    start = 0; redirect_en = 0; out_ready = 1;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
